// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared state type and default widths for the factorial sequencer
package fact_pkg;
   localparam int FACT_N_W = 5;
   localparam int FACT_R_W = 32;
   localparam int FACT_P_W = FACT_R_W + FACT_N_W;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      MUL,
      DONE
   } fact_state_t;
endpackage

// File: rtl/fact_down_cnt.sv
// rtl/fact_down_cnt.sv - loadable down counter with a count<=1 flag
module fact_down_cnt
   import fact_pkg::*;
#(
   parameter int W = FACT_N_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         le1
);

   assign le1 = (count <= W'(1));

   // The decrement is gated by le1 so the counter can never wrap below 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !le1) begin
         count <= count - W'(1);
      end
   end

endmodule

// File: rtl/fact_sequencer.sv
// rtl/fact_sequencer.sv - control FSM driving a shared multiplier to compute n!
module fact_sequencer
   import fact_pkg::*;
#(
   parameter int N_W = FACT_N_W,
   parameter int R_W = FACT_R_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [N_W-1:0]   n_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [R_W-1:0]   result_o,
   output logic             overflow_o,
   output logic             mul_req_o,
   output logic [R_W-1:0]   mul_a_o,
   output logic [N_W-1:0]   mul_b_o,
   input  logic             mul_ack_i,
   input  logic [R_W+N_W-1:0] mul_p_i
);

   localparam int P_W = R_W + N_W;

   fact_state_t    state;
   logic [R_W-1:0] acc;
   logic           ovf_acc;
   logic [N_W-1:0] cnt;
   logic           cnt_le1;
   logic           cnt_load;
   logic           take_ack;

   // Abort wins over an ack arriving in the same cycle.
   assign take_ack = (state == MUL) && mul_req_o && mul_ack_i && !abort_i;
   assign cnt_load = (state == IDLE) && start_i;

   fact_down_cnt #(.W(N_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (n_i),
      .dec      (take_ack),
      .count    (cnt),
      .le1      (cnt_le1)
   );

   assign mul_a_o = acc;
   assign mul_b_o = cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         mul_req_o  <= 1'b0;
         result_o   <= '0;
         overflow_o <= 1'b0;
         acc        <= R_W'(1);
         ovf_acc    <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (abort_i && (state != IDLE)) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            mul_req_o <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_i) begin
                     acc     <= R_W'(1);
                     ovf_acc <= 1'b0;
                     busy_o  <= 1'b1;
                     state   <= CHECK;
                  end
               end
               CHECK: begin
                  if (cnt_le1) begin
                     state      <= DONE;
                     done_o     <= 1'b1;
                     result_o   <= acc;
                     overflow_o <= ovf_acc;
                  end else begin
                     state     <= MUL;
                     mul_req_o <= 1'b1;
                  end
               end
               MUL: begin
                  if (mul_ack_i) begin
                     acc       <= mul_p_i[R_W-1:0];
                     ovf_acc   <= ovf_acc | (|mul_p_i[P_W-1:R_W]);
                     mul_req_o <= 1'b0;
                     state     <= CHECK;
                  end
               end
               DONE: begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
               default: begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fact_sequencer.sv
// tb/tb_fact_sequencer.sv - directed vector bench for fact_sequencer
module tb_fact_sequencer;

   localparam int N_W = 5;
   localparam int R_W = 32;
   localparam int P_W = R_W + N_W;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start_i = 1'b0;
   logic [N_W-1:0] n_i = '0;
   logic           abort_i = 1'b0;
   logic           busy_o;
   logic           done_o;
   logic [R_W-1:0] result_o;
   logic           overflow_o;
   logic           mul_req_o;
   logic [R_W-1:0] mul_a_o;
   logic [N_W-1:0] mul_b_o;
   logic           mul_ack_i;
   logic [P_W-1:0] mul_p_i;

   // Multiplier model state, written only by the model process.
   logic           model_ack = 1'b0;
   logic [P_W-1:0] model_p = '0;
   bit             in_req = 1'b0;
   logic [R_W-1:0] ref_a = '0;
   logic [N_W-1:0] ref_b = '0;
   int             wait_left = 0;
   int             total_wait = 0;
   int             stab_bad = 0;
   int             b_log[$];

   // Stimulus-side controls, written only by the test process.
   bit             model_en = 1'b1;
   int             max_delay = 0;
   logic           inj_ack = 1'b0;
   logic [P_W-1:0] inj_p = '0;

   int vectors = 0;
   int miscompares = 0;

   assign mul_ack_i = model_ack | inj_ack;
   assign mul_p_i   = inj_ack ? inj_p : model_p;

   fact_sequencer #(.N_W(N_W), .R_W(R_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_i    (start_i),
      .n_i        (n_i),
      .abort_i    (abort_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .result_o   (result_o),
      .overflow_o (overflow_o),
      .mul_req_o  (mul_req_o),
      .mul_a_o    (mul_a_o),
      .mul_b_o    (mul_b_o),
      .mul_ack_i  (mul_ack_i),
      .mul_p_i    (mul_p_i)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mul_req_o && model_en) begin
         if (!in_req) begin
            in_req    = 1'b1;
            ref_a     = mul_a_o;
            ref_b     = mul_b_o;
            wait_left = int'($urandom_range(0, max_delay));
            b_log.push_back(int'(mul_b_o));
         end else if (mul_a_o !== ref_a || mul_b_o !== ref_b) begin
            stab_bad++;
         end
         if (wait_left == 0) begin
            model_ack = 1'b1;
            model_p   = P_W'(ref_a) * P_W'(ref_b);
         end else begin
            model_ack = 1'b0;
            wait_left--;
            total_wait++;
         end
      end else begin
         in_req    = 1'b0;
         model_ack = 1'b0;
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input int n, input int maxd, input bit poke, input longint exp_res,
                         input bit exp_ovf, input int exp_muls, input int exp_cyc);
      int cyc;
      int w0;
      int s0;
      int b0;
      int nb;
      logic [R_W-1:0] prev;
      bit held;
      max_delay = maxd;
      w0   = total_wait;
      s0   = stab_bad;
      b0   = b_log.size();
      prev = result_o;
      held = 1'b1;
      n_i = N_W'(n);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      cyc = 1;
      chk($sformatf("busy_after_start n=%0d", n), longint'(busy_o), 1);
      while (!done_o && cyc < 500) begin
         if (result_o !== prev) held = 1'b0;
         if (poke) begin
            start_i = 1'($urandom_range(0, 1));
            n_i     = N_W'($urandom_range(0, 31));
         end
         tick();
         cyc++;
      end
      start_i = 1'b0;
      chk($sformatf("done_cycle n=%0d", n), cyc, exp_cyc + (total_wait - w0));
      chk($sformatf("result n=%0d", n), longint'(result_o), exp_res);
      chk($sformatf("overflow n=%0d", n), longint'(overflow_o), longint'(exp_ovf));
      chk($sformatf("result_held n=%0d", n), longint'(held), 1);
      chk($sformatf("operand_stable n=%0d", n), stab_bad - s0, 0);
      nb = b_log.size() - b0;
      chk($sformatf("mul_count n=%0d", n), nb, exp_muls);
      for (int i = 0; i < nb && i < exp_muls; i++)
         chk($sformatf("b_operand n=%0d idx=%0d", n, i), b_log[b0 + i], n - i);
      tick();
      chk($sformatf("done_pulse_end n=%0d", n), longint'(done_o), 0);
      chk($sformatf("idle_after_done n=%0d", n), longint'(busy_o), 0);
   endtask

   typedef struct {
      int     n;
      int     maxd;
      bit     poke;
      longint exp_res;
      bit     exp_ovf;
      int     exp_muls;
      int     exp_cyc;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int cyc;
      int rises;
      bit prev_req;

      tbl[0] = '{5,  0, 1'b0, 120,        1'b0, 4,  10};
      tbl[1] = '{0,  0, 1'b0, 1,          1'b0, 0,  2};
      tbl[2] = '{1,  0, 1'b0, 1,          1'b0, 0,  2};
      tbl[3] = '{2,  0, 1'b0, 2,          1'b0, 1,  4};
      tbl[4] = '{12, 0, 1'b0, 479001600,  1'b0, 11, 24};
      tbl[5] = '{13, 0, 1'b0, 1932053504, 1'b1, 12, 26};
      tbl[6] = '{6,  3, 1'b1, 720,        1'b0, 5,  12};
      tbl[7] = '{4,  2, 1'b1, 24,         1'b0, 3,  8};

      repeat (3) tick();
      chk("rst_busy", longint'(busy_o), 0);
      chk("rst_done", longint'(done_o), 0);
      chk("rst_req", longint'(mul_req_o), 0);
      chk("rst_result", longint'(result_o), 0);
      chk("rst_overflow", longint'(overflow_o), 0);
      chk("rst_mul_a", longint'(mul_a_o), 1);
      chk("rst_mul_b", longint'(mul_b_o), 0);
      reset = 1'b0;
      tick();

      foreach (tbl[i])
         run_op(tbl[i].n, tbl[i].maxd, tbl[i].poke, tbl[i].exp_res,
                tbl[i].exp_ovf, tbl[i].exp_muls, tbl[i].exp_cyc);

      // Reset while a multiply is outstanding.
      max_delay = 0;
      n_i = 5'd7;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      cyc = 0;
      while (!mul_req_o && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("midrst_reached_mul", longint'(mul_req_o), 1);
      reset = 1'b1;
      tick();
      chk("midrst_busy", longint'(busy_o), 0);
      chk("midrst_req", longint'(mul_req_o), 0);
      chk("midrst_result", longint'(result_o), 0);
      chk("midrst_overflow", longint'(overflow_o), 0);
      reset = 1'b0;
      tick();
      run_op(3, 0, 1'b0, 6, 1'b0, 2, 6);
      run_op(4, 0, 1'b0, 24, 1'b0, 3, 8);

      // Abort during the second multiply of n=9; the model acks in that same cycle.
      n_i = 5'd9;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      cyc = 0;
      rises = 0;
      prev_req = 1'b0;
      while (cyc < 40) begin
         if (mul_req_o && !prev_req) rises++;
         prev_req = mul_req_o;
         if (rises == 2) break;
         tick();
         cyc++;
      end
      chk("abort_reached_mul2", rises, 2);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("abort_busy", longint'(busy_o), 0);
      chk("abort_req", longint'(mul_req_o), 0);
      chk("abort_done", longint'(done_o), 0);
      chk("abort_result", longint'(result_o), 24);
      chk("abort_acc_kept", longint'(mul_a_o), 9);
      chk("abort_cnt_kept", longint'(mul_b_o), 8);

      model_en = 1'b0;
      inj_p    = 37'h1F_0000_0001;
      inj_ack  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("late_ack_busy", longint'(busy_o), 0);
         chk("late_ack_done", longint'(done_o), 0);
         chk("late_ack_acc", longint'(mul_a_o), 9);
      end
      inj_ack  = 1'b0;
      model_en = 1'b1;

      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("idle_abort_busy", longint'(busy_o), 0);
      chk("idle_abort_result", longint'(result_o), 24);

      run_op(3, 1, 1'b0, 6, 1'b0, 2, 6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fact_sequencer.md
Name: fact_sequencer

Overview:
Control FSM for the factorial machine. Accepts an operand n, then drives an external shared multiplier through a req/ack handshake to compute n! iteratively: acc = acc * cnt, with cnt counting down from n to 2. Holds the final result and a sticky overflow flag. Sits between the top-level command interface and the multiplier/register datapath.

Parameters:
N_W, 5, operand/counter width (n range 0..31)
R_W, 32, accumulator/result width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start_i  in  1  start request, sampled only in IDLE
n_i  in  N_W  operand, captured with start_i
abort_i  in  1  cancel current computation
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle completion pulse
result_o  out  R_W  last completed n! (low R_W bits)
overflow_o  out  1  last result exceeded R_W bits
mul_req_o  out  1  multiply request
mul_a_o  out  R_W  multiplicand (acc)
mul_b_o  out  N_W  multiplier (cnt)
mul_ack_i  in  1  product valid, sampled only while mul_req_o=1
mul_p_i  in  R_W+N_W  full product

Behaviour:
- Only one clock, clk; reset is synchronous and active-high. Every register, including all outputs, is updated only on the rising edge of clk.
- Reset (at any time, including mid-operation): state=IDLE; busy_o=0, done_o=0, mul_req_o=0, result_o=0, overflow_o=0, acc=1, cnt=0, ovf_acc=0. mul_a_o and mul_b_o reflect acc and cnt.
- States: IDLE, CHECK, MUL, DONE.
- IDLE: if start_i=1, then cnt<=n_i, acc<=1, ovf_acc<=0, and go to CHECK. Otherwise stay in IDLE.
- CHECK: if cnt<=1, go to DONE. Otherwise go to MUL.
- MUL: mul_req_o=1, mul_a_o=acc, mul_b_o=cnt. All three are held stable until ack.
  - On mul_ack_i=1: acc<=mul_p_i[R_W-1:0]; ovf_acc<=ovf_acc | (|mul_p_i[R_W+N_W-1:R_W]); cnt<=cnt-1; go to CHECK.
  - Without ack: stay in MUL, with no timeout.
- DONE: done_o=1 for exactly this cycle. result_o<=acc and overflow_o<=ovf_acc are loaded on DONE entry. Next state is IDLE.
- result_o and overflow_o change only on DONE entry or reset. They stay stable during a later computation.
- start_i while busy_o=1: ignored and not queued.
- abort_i (busy_o=1): next state is IDLE, mul_req_o drops next cycle, result_o and overflow_o are unchanged, and no done_o pulse occurs. Reset takes priority over abort_i. abort_i in IDLE has no effect. abort_i takes priority over mul_ack_i in the same cycle.
- mul_ack_i while mul_req_o=0: ignored.
- n=0 and n=1 both give result 1, with no multiplier request.
- Latency with zero-wait ack (ack in the first MUL cycle):
  - Take cycle 0 as the cycle start_i is sampled.
  - done_o is high in cycle 2*max(n,1).
  - Each extra wait cycle in MUL adds 1.
- Multiply count is max(n-1,0). The b operands are n, n-1, ..., 2, in that order.
- Counter never wraps: the decrement is only taken from cnt>=2.

Decomposition:
- Package fact_pkg: state enum (IDLE, CHECK, MUL, DONE), default widths N_W and R_W, and the product width constant R_W+N_W.
- Sub-module fact_down_cnt (N_W bits):
  - Inputs: load, load value, dec. Outputs: count, le1 flag (count<=1).
  - Same synchronous active-high reset to 0.
- The FSM, accumulator, and result registers stay in fact_sequencer.

Test Plan:
- Reset mid-computation (n=7, asserted while in MUL) -> next cycle: busy_o=0, mul_req_o=0, result_o=0, overflow_o=0; a subsequent n=3 run yields 6.
- n=5, zero-wait multiplier model -> 4 requests with b=5,4,3,2; done_o high only in cycle 10; result_o=120; overflow_o=0.
- n=0 and n=1 -> no mul_req_o; done_o in cycle 2; result_o=1.
- n=12 -> result_o=479001600, overflow_o=0. Then n=13 -> overflow_o=1 and result_o=6227020800 mod 2^32=1932053504. result_o holds 479001600 until the n=13 DONE cycle.
- Random 0-3 cycle ack delays with n=6 -> mul_a_o/mul_b_o stable while waiting; result_o=720; done_o cycle = 12 + total wait cycles. start_i pulses while busy are ignored.
- abort_i asserted during the 2nd MUL of n=9 (previous result 24) -> IDLE next cycle, no done_o, result_o stays 24; a late mul_ack_i is ignored.
